traffic_lights: RTL and testbench
=================================

# traffic_lights

Two-road intersection controller: main road (NS) has priority and rests on green; a side-road (EW) car sensor `x` requests a crossing phase. A single phase counter times the minimum main green, yellow, all-red and maximum side green intervals. It is a standalone leaf block whose registered 2-bit lamp codes drive the signal-head drivers directly.

## Interface
- `NS_MIN_GREEN`, default 8: minimum cycles NS stays green before EW can be served (1..255).
- `YELLOW_CYCLES`, default 3: cycles spent in each yellow phase (1..255).
- `ALLRED_CYCLES`, default 2: cycles spent in each all-red clearance phase (1..255).
- `EW_MAX_GREEN`, default 10: maximum cycles EW stays green (1..255).
- `clk`  in  1  single clock; all state changes on rising edge.
- `clear`  in  1  reset, asynchronous, active-low.
- `x`  in  1  EW car present; synchronous to `clk`, sampled on rising edge; no internal synchronizer.
- `NS`  out  2  NS lamp code: 00 RED, 01 YELLOW, 10 GREEN; 11 never driven.
- `EW`  out  2  EW lamp code, same encoding.

## Operation
- Six-state FSM, six-entry cyclic sequence; outputs decoded from the state register only (Moore):
  - NS_GREEN (NS=GREEN, EW=RED)
  - NS_YELLOW (YELLOW, RED)
  - RED1 (RED, RED)
  - EW_GREEN (RED, GREEN)
  - EW_YELLOW (RED, YELLOW)
  - RED2 (RED, RED)
- Phase counter, 8 bits: 0 on every state entry, +1 each cycle while the state is held; saturates at 255.
- Transitions (evaluated each rising edge; `cnt` = cycles already spent in the state minus 1):
  - NS_GREEN -> NS_YELLOW when `x`=1 and `cnt` >= NS_MIN_GREEN-1; otherwise hold indefinitely.
  - NS_YELLOW -> RED1 when `cnt` = YELLOW_CYCLES-1.
  - RED1 -> EW_GREEN when `cnt` = ALLRED_CYCLES-1.
  - EW_GREEN -> EW_YELLOW when `x`=0 or `cnt` = EW_MAX_GREEN-1; minimum one cycle of EW green.
  - EW_YELLOW -> RED2 when `cnt` = YELLOW_CYCLES-1.
  - RED2 -> NS_GREEN when `cnt` = ALLRED_CYCLES-1.
- `x` is ignored in every state other than NS_GREEN and EW_GREEN. Request dropping during NS_YELLOW/RED1 does not abort the sequence.
- Safety invariants: never both roads non-RED; every GREEN->RED change passes through YELLOW and then all-red; code 11 never appears.
- An illegal state register value (if the encoding has spare codes) recovers to NS_GREEN on the next edge.

## Timing
- Reset (`clear`=0): immediately, without a clock, state=NS_GREEN, counter=0, NS=10, EW=00; held while `clear`=0.
- First rising edge after `clear` rises: counter 0->1 in NS_GREEN; the NS_MIN_GREEN window counts from reset release.
- Outputs change on the same rising edge that changes state; no extra latency, no combinational path from `x` to outputs.
- Phase durations with defaults:
  - NS_GREEN >= 8 cycles
  - NS_YELLOW 3 cycles
  - RED1 2 cycles
  - EW_GREEN 1..10 cycles
  - EW_YELLOW 3 cycles
  - RED2 2 cycles
- With `x` held 1 continuously: period exactly 8+3+2+10+3+2 = 28 cycles; NS green 8, EW green 10.
- If `x` rises after the NS minimum has elapsed, NS_YELLOW starts on the first edge sampling `x`=1.
- Reset asserted mid-phase: immediate return to NS_GREEN/RED regardless of phase.

## Structure
- Package `traffic_lights_pkg`:
  - lamp codes RED/YELLOW/GREEN as a 2-bit enum
  - state enum (6 states)
  - counter width localparam (8)
- Sub-module `tl_phase_timer`: 8-bit counter with synchronous restart on state change, async active-low clear, saturation, and compare against a target. Instantiated once.
- Top `traffic_lights`: FSM, next-state logic, output decode.

## Test plan
- Reset: `clear`=0 for 5 cycles, `x`=0 -> NS=10, EW=00 during and after reset; no change for 50 cycles.
- Min green: release reset, raise `x`=1 at cycle 3 -> NS_YELLOW begins at cycle 8 after release, then RED1 2 cycles, then EW=10.
- Continuous demand: `x`=1 forever -> repeating 28-cycle pattern, EW green exactly 10 cycles; NS/EW never both non-00.
- Early release: in EW_GREEN drop `x` after 4 cycles -> EW_YELLOW on the next edge, then RED2 2 cycles, then NS=10.
- Late request: `x`=1 at cycle 20 after release -> NS=01 on the first edge sampling `x`=1.
- Async reset mid-EW_GREEN: pull `clear` low between edges -> NS=10, EW=00 immediately; resumes with a full 8-cycle minimum after release.

Source files
------------

// File: rtl/traffic_lights_pkg.sv
// Shared types for the two-road traffic light controller.
//   lamp_e  : 2-bit lamp code driven to the signal heads (11 unused)
//   state_e : controller phase, in cyclic order
//   CNT_W   : width of the phase counter
package traffic_lights_pkg;

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10
  } lamp_e;

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_RED1      = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_RED2      = 3'd5
  } state_e;

  // Lamp decode per phase; anything outside the six phases shows all-red.
  function automatic lamp_e ns_lamp(state_e s);
    case (s)
      S_NS_GREEN:  return GREEN;
      S_NS_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

  function automatic lamp_e ew_lamp(state_e s);
    case (s)
      S_EW_GREEN:  return GREEN;
      S_EW_YELLOW: return YELLOW;
      default:     return RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_lights_timer.sv
// Phase timer: saturating counter restarted whenever the phase changes.
//   clk     : clock
//   rst_n   : asynchronous active-low clear (counter -> 0)
//   restart : synchronous restart, counter loads 0 on this edge
//   target  : compare value for the current phase
//   done    : counter has reached or passed target
module tl_phase_timer
  import traffic_lights_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [CNT_W-1:0] target,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // >= rather than == so the open-ended NS green hold keeps its exit enabled
  // once the minimum has elapsed; fixed-length phases leave at equality anyway.
  assign done = (cnt_q >= target);

endmodule

// File: rtl/traffic_lights.sv
// Two-road intersection controller. Main road (NS) rests on green; the
// side-road sensor x requests an EW crossing phase.
//   clk   : clock, all state changes on rising edge
//   clear : asynchronous active-low reset (NS green, EW red)
//   x     : EW car present, synchronous to clk
//   NS    : registered NS lamp code (00 red, 01 yellow, 10 green)
//   EW    : registered EW lamp code, same encoding
module traffic_lights
  import traffic_lights_pkg::*;
#(
  parameter int unsigned NS_MIN_GREEN  = 8,
  parameter int unsigned YELLOW_CYCLES = 3,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned EW_MAX_GREEN  = 10
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       x,
  output logic [1:0] NS,
  output logic [1:0] EW
);

  localparam logic [CNT_W-1:0] NS_MIN_T = CNT_W'(NS_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_T    = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_T = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] EW_MAX_T = CNT_W'(EW_MAX_GREEN - 1);

  state_e           state_q;
  state_e           state_d;
  lamp_e            ns_q;
  lamp_e            ew_q;
  lamp_e            ns_d;
  lamp_e            ew_d;
  logic [CNT_W-1:0] target;
  logic             done;
  logic             restart;

  tl_phase_timer u_timer (
    .clk     (clk),
    .rst_n   (clear),
    .restart (restart),
    .target  (target),
    .done    (done)
  );

  always_comb begin
    state_d = state_q;
    target  = '0;
    case (state_q)
      S_NS_GREEN: begin
        target = NS_MIN_T;
        if (x && done) state_d = S_NS_YELLOW;
      end
      S_NS_YELLOW: begin
        target = YEL_T;
        if (done) state_d = S_RED1;
      end
      S_RED1: begin
        target = ALLRED_T;
        if (done) state_d = S_EW_GREEN;
      end
      S_EW_GREEN: begin
        target = EW_MAX_T;
        if (!x || done) state_d = S_EW_YELLOW;
      end
      S_EW_YELLOW: begin
        target = YEL_T;
        if (done) state_d = S_RED2;
      end
      S_RED2: begin
        target = ALLRED_T;
        if (done) state_d = S_NS_GREEN;
      end
      default: state_d = S_NS_GREEN;
    endcase
  end

  // Counter restarts on every phase entry, including illegal-state recovery.
  assign restart = (state_d != state_q);

  // Lamps are decoded from the next state and registered alongside it, so
  // they change on the same edge as the state with no path from x.
  always_comb begin
    ns_d = ns_lamp(state_d);
    ew_d = ew_lamp(state_d);
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_NS_GREEN;
      ns_q    <= GREEN;
      ew_q    <= RED;
    end else begin
      state_q <= state_d;
      ns_q    <= ns_d;
      ew_q    <= ew_d;
    end
  end

  assign NS = ns_q;
  assign EW = ew_q;

endmodule

// File: tb/tb_traffic_lights.sv
module tb_traffic_lights;

  logic       clk   = 1'b0;
  logic       clear = 1'b1;
  logic       x     = 1'b0;
  logic [1:0] NS;
  logic [1:0] EW;

  localparam logic [1:0] R = 2'b00;
  localparam logic [1:0] Y = 2'b01;
  localparam logic [1:0] G = 2'b10;

  always #5 clk = ~clk;

  traffic_lights #(
    .NS_MIN_GREEN  (8),
    .YELLOW_CYCLES (3),
    .ALLRED_CYCLES (2),
    .EW_MAX_GREEN  (10)
  ) dut (
    .clk   (clk),
    .clear (clear),
    .x     (x),
    .NS    (NS),
    .EW    (EW)
  );

  typedef struct {
    logic [3:0] lamps;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed NS/EW=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive x, wait past the edge, pop the expectation and compare.
  task automatic tick(input logic xv);
    exp_t e;
    x = xv;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_underflow: observed empty queue expected an entry");
    end else begin
      e = sb.pop_front();
      check(e.tag, {NS, EW}, e.lamps);
    end
    checks++;
    assert ((NS == R || EW == R) && NS != 2'b11 && EW != 2'b11) else begin
      errors++;
      $error("FAIL safety: observed NS=%b EW=%b expected one road red, no 11", NS, EW);
    end
  endtask

  task automatic run(input int unsigned n, input logic xv, input logic [1:0] ns,
                     input logic [1:0] ew, input string tag);
    exp_t e;
    for (int unsigned i = 0; i < n; i++) begin
      e.lamps = {ns, ew};
      e.tag   = tag;
      sb.push_back(e);
      tick(xv);
    end
  endtask

  // Assert clear between edges, check the lamps react without a clock,
  // hold two cycles, then release just after an edge.
  task automatic pulse_reset(input logic xv, input string tag);
    #2;
    clear = 1'b0;
    #1;
    check(tag, {NS, EW}, {G, R});
    run(2, xv, G, R, "reset_hold");
    clear = 1'b1;
  endtask

  initial begin
    // Power-on reset, held 5 cycles, then idle with no demand.
    #1;
    clear = 1'b0;
    #1;
    check("reset_async", {NS, EW}, {G, R});
    run(5, 1'b0, G, R, "reset_5cyc");
    clear = 1'b1;
    run(50, 1'b0, G, R, "idle_no_demand");

    // Minimum green: x rises at cycle 3, yellow begins at edge 8.
    pulse_reset(1'b0, "reset_pulse_a");
    run(2, 1'b0, G, R, "min_green_pre");
    run(5, 1'b1, G, R, "min_green_hold");
    run(3, 1'b1, Y, R, "ns_yellow");
    run(2, 1'b1, R, R, "red1");
    // Early release: x drops after 4 cycles of EW green.
    run(4, 1'b1, R, G, "ew_green_short");
    run(3, 1'b0, R, Y, "ew_yellow_early");
    run(2, 1'b0, R, R, "red2");
    run(5, 1'b0, G, R, "ns_return");

    // Late request: x first sampled at edge 20 gives yellow immediately.
    pulse_reset(1'b0, "reset_pulse_b");
    run(19, 1'b0, G, R, "late_wait");
    run(3, 1'b1, Y, R, "late_yellow");
    run(2, 1'b1, R, R, "late_red1");
    run(10, 1'b1, R, G, "ew_max_green");
    run(3, 1'b1, R, Y, "ew_yellow_max");
    run(2, 1'b1, R, R, "red2_max");

    // Continuous demand: two full 28-cycle periods.
    for (int k = 0; k < 2; k++) begin
      run(8, 1'b1, G, R, "cont_ns_green");
      run(3, 1'b1, Y, R, "cont_ns_yellow");
      run(2, 1'b1, R, R, "cont_red1");
      run(10, 1'b1, R, G, "cont_ew_green");
      run(3, 1'b1, R, Y, "cont_ew_yellow");
      run(2, 1'b1, R, R, "cont_red2");
    end

    // Async reset in the middle of EW green, then a full minimum again.
    run(8, 1'b1, G, R, "pre_mid_ns_green");
    run(3, 1'b1, Y, R, "pre_mid_ns_yellow");
    run(2, 1'b1, R, R, "pre_mid_red1");
    run(3, 1'b1, R, G, "pre_mid_ew_green");
    pulse_reset(1'b1, "reset_mid_ew");
    run(7, 1'b1, G, R, "post_reset_min");
    run(1, 1'b1, Y, R, "post_reset_yellow");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
